multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Control unit for the multicycle ARM-subset processor.
- Decodes the latched instruction fields (Op, Funct, Rd) and sequences each instruction through a Moore state machine.
- Drives the datapath mux selects and enables.
- Is the producer side of the condition-logic interface: emits PCS, RegW, MemW, FlagW and NoWrite, which the conditional logic gates with CondEx, plus NextPC, which bypasses the condition check.

Parameters:
STATE_W, 4, width of the state register and debug state output.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
Funct  in  6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-processing) or L (memory).
Rd  in  4  Instr[15:12].
PCS  out  1  PC write request, conditional.
RegW  out  1  register-file write request, conditional.
MemW  out  1  memory write request, conditional.
NoWrite  out  1  suppress register write (CMP or undefined cmd).
FlagW  out  2  [1]=NZ write, [0]=CV write.
NextPC  out  1  unconditional PC increment write.
IRWrite  out  1  instruction register load.
AdrSrc  out  1  memory address: 0=PC, 1=ALUResult register.
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
ALUSrcA  out  2  00 RD1 register, 01 PC, 10 ALUOut.
ALUSrcB  out  2  00 WriteData, 01 ExtImm, 10 constant 4.
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
ImmSrc  out  2  equals Op.
RegSrc  out  2  [1]=(Op==01), [0]=(Op==10).
State  out  STATE_W  current state, debug only.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Encodings 10-15 go to FETCH on the next edge.

Transitions:
- FETCH -> DECODE.
- DECODE, by Op:
  - Op=01 -> MEMADR.
  - Op=00 with Funct[5]=0 -> EXECUTER.
  - Op=00 with Funct[5]=1 -> EXECUTEI.
  - Op=10 -> BRANCH.
  - Op=11 -> FETCH (instruction skipped, no strobes).
- MEMADR: Funct[0]=1 -> MEMREAD, otherwise -> MEMWRITE.
- MEMREAD -> MEMWB -> FETCH.
- MEMWRITE -> FETCH.
- EXECUTER / EXECUTEI -> ALUWB -> FETCH.
- BRANCH -> FETCH.
- Latency per instruction class: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined 2.

Moore outputs (unlisted fields are 0):
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUOp=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1.
- ALUWB: RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.

Derived outputs:
- PCS = Branch | (RegW & Rd==15).
- ALU decode when ALUOp=0: ALUControl=00, FlagW=00, NoWrite=0.
- ALU decode when ALUOp=1, by cmd:
  - 0100 ADD -> 00.
  - 0010 SUB -> 01.
  - 0000 AND -> 10.
  - 1100 ORR -> 11.
  - 1010 CMP -> 01 with NoWrite=1.
  - Any other cmd -> 00 with NoWrite=1 and FlagW=00.
- FlagW[1]=S; FlagW[0]=S & arithmetic (ADD/SUB/CMP).
- FlagW is therefore a single-cycle pulse in EXECUTER/EXECUTEI only.
- NoWrite is registered at the end of EXECUTE and held through ALUWB, so that RegW&~NoWrite blocks the CMP writeback.

Reset:
- Asynchronous: state goes to FETCH immediately.
- While reset=1, all strobes (IRWrite, NextPC, PCS, RegW, MemW, FlagW, NoWrite) are forced to 0; the mux selects hold their FETCH values.
- The first clock edge after deassertion performs the FETCH load.
- Reset mid-instruction aborts that instruction with no further strobes.

Simultaneity:
- Op, Funct and Rd come from the IR and are stable from DECODE onward. The FSM samples them only in DECODE and MEMADR.
- Rd==15 on an STR does not assert PCS, because RegW=0.

Test Plan:
1. Reset asserted mid-MEMREAD, released -> State=0 with all strobes 0 during reset; the next cycle has IRWrite=1 and NextPC=1.
2. ADD R1 (Op=00, Funct=001000, Rd=1) -> states 0,1,6,8,0; ALUControl=00 in cycle 3; RegW=1 in cycle 4 only; FlagW=00 throughout.
3. CMP (Funct=010101) -> FlagW=11 and ALUControl=01 in EXECUTER; NoWrite=1 while RegW=1 in ALUWB.
4. LDR PC (Op=01, Funct[0]=1, Rd=15) -> states 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01, RegW=1 and PCS=1 in MEMWB.
5. STR then B (Op=01 with L=0, then Op=10) -> MemW=1 only in MEMWRITE; PCS=1, ALUSrcA=10 and ALUSrcB=01 only in BRANCH; 4-cycle then 3-cycle sequences.
6. Op=11 and undefined cmd 0111 -> Op=11 goes DECODE->FETCH with no strobes; cmd 0111 gives ALUControl=00 with NoWrite=1 held through ALUWB.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Control unit for the multicycle ARM-subset processor.
//                Sequences each instruction through a Moore state machine,
//                drives the datapath mux selects and enables, and produces
//                the condition-gated write requests (PCS, RegW, MemW, FlagW,
//                NoWrite) plus the unconditional NextPC strobe.
//
//  Ports
//    clk        : system clock, rising edge
//    reset      : asynchronous active-high reset
//    Op         : Instr[27:26] instruction class
//    Funct      : Instr[25:20] {I, cmd[3:0], S/L}
//    Rd         : Instr[15:12] destination register
//    PCS        : PC write request (conditional)
//    RegW       : register-file write request (conditional)
//    MemW       : memory write request (conditional)
//    NoWrite    : suppress register write (CMP / undefined cmd)
//    FlagW      : [1] NZ write, [0] CV write (conditional)
//    NextPC     : unconditional PC increment write
//    IRWrite    : instruction register load
//    AdrSrc     : memory address select (0 PC, 1 ALUResult reg)
//    ResultSrc  : result mux select (00 ALUOut, 01 Data, 10 ALUResult)
//    ALUSrcA    : ALU A select (00 RD1, 01 PC, 10 ALUOut)
//    ALUSrcB    : ALU B select (00 WriteData, 01 ExtImm, 10 const 4)
//    ALUControl : 00 ADD, 01 SUB, 10 AND, 11 ORR
//    ImmSrc     : immediate extension select (equals Op)
//    RegSrc     : register read address selects
//    State      : current state (debug only)
//
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic [3:0]         Rd,
   output logic               PCS,
   output logic               RegW,
   output logic               MemW,
   output logic               NoWrite,
   output logic [1:0]         FlagW,
   output logic               NextPC,
   output logic               IRWrite,
   output logic               AdrSrc,
   output logic [1:0]         ResultSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUControl,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         RegSrc,
   output logic [STATE_W-1:0] State
);

   localparam logic [STATE_W-1:0] c_fetch    = STATE_W'(0);
   localparam logic [STATE_W-1:0] c_decode   = STATE_W'(1);
   localparam logic [STATE_W-1:0] c_memadr   = STATE_W'(2);
   localparam logic [STATE_W-1:0] c_memread  = STATE_W'(3);
   localparam logic [STATE_W-1:0] c_memwb    = STATE_W'(4);
   localparam logic [STATE_W-1:0] c_memwrite = STATE_W'(5);
   localparam logic [STATE_W-1:0] c_executer = STATE_W'(6);
   localparam logic [STATE_W-1:0] c_executei = STATE_W'(7);
   localparam logic [STATE_W-1:0] c_aluwb    = STATE_W'(8);
   localparam logic [STATE_W-1:0] c_branch   = STATE_W'(9);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next_state;
   logic               r_nowrite;

   // raw Moore outputs, before reset gating / decode
   logic       w_irwrite;
   logic       w_nextpc;
   logic       w_regw;
   logic       w_memw;
   logic       w_branch;
   logic       w_aluop;
   logic       w_adrsrc;
   logic [1:0] w_resultsrc;
   logic [1:0] w_alusrca;
   logic [1:0] w_alusrcb;

   // ALU decode
   logic [3:0] w_cmd;
   logic       w_s;
   logic [1:0] w_alucontrol;
   logic [1:0] w_flagw;
   logic       w_dec_nowrite;
   logic       w_arith;
   logic       w_flag_en;
   logic       w_nowrite_raw;

   assign w_cmd = Funct[4:1];
   assign w_s   = Funct[0];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_fetch;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NoWrite is captured at the end of EXECUTE so that it still blocks the
   // write in ALUWB, where ALUOp is no longer asserted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_nowrite <= 1'b0;
      end else if (r_state == c_executer || r_state == c_executei) begin
         r_nowrite <= w_dec_nowrite;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_next_state = c_fetch;
      case (r_state)
         c_fetch:  w_next_state = c_decode;
         c_decode: begin
            case (Op)
               2'b00:   w_next_state = Funct[5] ? c_executei : c_executer;
               2'b01:   w_next_state = c_memadr;
               2'b10:   w_next_state = c_branch;
               default: w_next_state = c_fetch;  // undefined class skipped
            endcase
         end
         c_memadr:   w_next_state = Funct[0] ? c_memread : c_memwrite;
         c_memread:  w_next_state = c_memwb;
         c_memwb:    w_next_state = c_fetch;
         c_memwrite: w_next_state = c_fetch;
         c_executer: w_next_state = c_aluwb;
         c_executei: w_next_state = c_aluwb;
         c_aluwb:    w_next_state = c_fetch;
         c_branch:   w_next_state = c_fetch;
         default:    w_next_state = c_fetch;  // unused encodings recover
      endcase
   end

   // ------------------------------------------------------------------------
   // Moore output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_irwrite   = 1'b0;
      w_nextpc    = 1'b0;
      w_regw      = 1'b0;
      w_memw      = 1'b0;
      w_branch    = 1'b0;
      w_aluop     = 1'b0;
      w_adrsrc    = 1'b0;
      w_resultsrc = 2'b00;
      w_alusrca   = 2'b00;
      w_alusrcb   = 2'b00;
      case (r_state)
         c_fetch: begin
            w_irwrite   = 1'b1;
            w_nextpc    = 1'b1;
            w_alusrca   = 2'b01;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
         end
         c_decode: begin
            w_alusrca   = 2'b01;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
         end
         c_memadr:   w_alusrcb = 2'b01;
         c_memread:  w_adrsrc  = 1'b1;
         c_memwb: begin
            w_resultsrc = 2'b01;
            w_regw      = 1'b1;
         end
         c_memwrite: begin
            w_adrsrc = 1'b1;
            w_memw   = 1'b1;
         end
         c_executer: w_aluop = 1'b1;
         c_executei: begin
            w_alusrcb = 2'b01;
            w_aluop   = 1'b1;
         end
         c_aluwb:    w_regw = 1'b1;
         c_branch: begin
            w_alusrca   = 2'b10;
            w_alusrcb   = 2'b01;
            w_resultsrc = 2'b10;
            w_branch    = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------------
   // ALU decode: only meaningful while ALUOp is asserted
   // ------------------------------------------------------------------------
   always_comb begin
      w_alucontrol  = 2'b00;
      w_dec_nowrite = 1'b0;
      w_arith       = 1'b0;
      w_flag_en     = 1'b0;
      w_flagw       = 2'b00;
      if (w_aluop) begin
         w_flag_en = 1'b1;
         case (w_cmd)
            4'b0100: w_arith = 1'b1;                       // ADD
            4'b0010: begin                                 // SUB
               w_alucontrol = 2'b01;
               w_arith      = 1'b1;
            end
            4'b0000: w_alucontrol = 2'b10;                 // AND
            4'b1100: w_alucontrol = 2'b11;                 // ORR
            4'b1010: begin                                 // CMP
               w_alucontrol  = 2'b01;
               w_arith       = 1'b1;
               w_dec_nowrite = 1'b1;
            end
            default: begin                                 // unsupported cmd
               w_dec_nowrite = 1'b1;
               w_flag_en     = 1'b0;
            end
         endcase
      end
      w_flagw = {w_s & w_flag_en, w_s & w_flag_en & w_arith};
   end

   // During EXECUTE the decode drives NoWrite directly; in ALUWB the
   // captured copy takes over.
   assign w_nowrite_raw = w_aluop ? w_dec_nowrite
                                  : ((r_state == c_aluwb) & r_nowrite);

   // Strobes are forced low while reset is held; selects simply follow the
   // FETCH state that reset forces.
   assign IRWrite    = w_irwrite & ~reset;
   assign NextPC     = w_nextpc & ~reset;
   assign RegW       = w_regw & ~reset;
   assign MemW       = w_memw & ~reset;
   assign PCS        = ~reset & (w_branch | (w_regw & (Rd == 4'hF)));
   assign FlagW      = reset ? 2'b00 : w_flagw;
   assign NoWrite    = w_nowrite_raw & ~reset;
   assign AdrSrc     = w_adrsrc;
   assign ResultSrc  = w_resultsrc;
   assign ALUSrcA    = w_alusrca;
   assign ALUSrcB    = w_alusrcb;
   assign ALUControl = w_alucontrol;
   assign ImmSrc     = Op;
   assign RegSrc     = {Op == 2'b01, Op == 2'b10};
   assign State      = r_state;

endmodule
`default_nettype wire
